// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and the prediction-metadata record for the fetch next-PC generator.
package fetch_pc_gen_pkg;

  // Default address width. The metadata record below is sized from this constant.
  localparam int unsigned PC_WIDTH = 32;

  // BTB index width. The index is taken from PC[BTB_IDX_W+1:2].
  localparam int unsigned BTB_IDX_W = 6;

  // PC value loaded while reset is asserted.
  localparam logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  // Byte stride between sequential instructions.
  localparam int unsigned PC_STEP = 4;

  // Per-instruction prediction record carried IF -> ID -> EX.
  // pred_target holds the PC that fetch actually went to next.
  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
  } pred_meta_t;

endpackage

// File: rtl/pred_meta_reg.sv
// One pipeline stage of prediction metadata, with flush, hold and bubble controls.
// Control priority: flush > hold > bubble > load.
module pred_meta_reg
  import fetch_pc_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       hold,
  input  logic       bubble,
  input  pred_meta_t d,
  output pred_meta_t q
);

  pred_meta_t meta_q;

  // Stage register. Flush and bubble only drop the valid bit; the payload
  // fields are don't-care once valid is low, so they are left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
    end else if (flush) begin
      meta_q.valid <= 1'b0;
    end else if (hold) begin
      meta_q <= meta_q;
    end else if (bubble) begin
      meta_q.valid <= 1'b0;
    end else begin
      meta_q <= d;
    end
  end

  assign q = meta_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator. Owns the fetch PC, indexes the BTB, chooses the
// next PC from the BTB/direction prediction, carries prediction metadata down to
// EX and resolves mispredictions there (redirect plus BTB update).
module fetch_pc_gen #(
  parameter int unsigned         PC_WIDTH  = fetch_pc_gen_pkg::PC_WIDTH,
  parameter int unsigned         BTB_IDX_W = fetch_pc_gen_pkg::BTB_IDX_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = fetch_pc_gen_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  output logic [PC_WIDTH-1:0]  pc_if,
  output logic [BTB_IDX_W-1:0] btb_rd_idx,
  input  logic [PC_WIDTH-1:0]  btb_target,
  input  logic                 btb_valid,
  input  logic                 pred_taken_in,
  input  logic                 ex_is_branch,
  input  logic                 ex_taken,
  input  logic [PC_WIDTH-1:0]  ex_target,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 btb_wr_en,
  output logic [BTB_IDX_W-1:0] btb_wr_idx,
  output logic [PC_WIDTH-1:0]  btb_wr_target
);

  import fetch_pc_gen_pkg::*;

  // Fetch-side signals.
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic                if_pred;
  logic [PC_WIDTH-1:0] next_seq;
  logic [PC_WIDTH-1:0] if_next;

  // Metadata pipeline.
  pred_meta_t          if_id_d;
  pred_meta_t          if_id_q;
  pred_meta_t          id_ex_q;

  // EX-side signals.
  logic                ex_valid;
  logic [PC_WIDTH-1:0] ex_pc;
  logic [PC_WIDTH-1:0] ex_seq;
  logic                ex_br_taken;
  logic                dir_wrong;
  logic                tgt_wrong;
  logic [PC_WIDTH-1:0] actual_next;

  assign pc_if      = pc_q;
  assign btb_rd_idx = pc_q[BTB_IDX_W+1:2];

  // IF prediction: follow the BTB only when the entry is valid and predicted taken.
  always_comb begin
    if_pred  = btb_valid & pred_taken_in;
    next_seq = pc_q + PC_WIDTH'(PC_STEP);
    if_next  = if_pred ? btb_target : next_seq;
  end

  // Record what fetch did for this PC so EX can check it later.
  always_comb begin
    if_id_d             = '0;
    if_id_d.valid       = 1'b1;
    if_id_d.pc          = pc_q;
    if_id_d.pred_taken  = if_pred;
    if_id_d.pred_target = if_next;
  end

  // EX resolution. Everything is qualified by the ID/EX valid bit so bubbles and
  // flushed slots never redirect or write the BTB.
  always_comb begin
    ex_valid    = id_ex_q.valid;
    ex_pc       = id_ex_q.pc;
    ex_seq      = ex_pc + PC_WIDTH'(PC_STEP);
    ex_br_taken = ex_is_branch & ex_taken;
    actual_next = ex_taken ? ex_target : ex_seq;
    // A non-branch that was predicted taken (aliased BTB entry) lands in dir_wrong.
    dir_wrong   = id_ex_q.pred_taken != ex_br_taken;
    tgt_wrong   = ex_br_taken & (id_ex_q.pred_target != ex_target);
    mispredict  = ex_valid & (dir_wrong | tgt_wrong);
    redirect_pc = ex_is_branch ? actual_next : ex_seq;
  end

  // BTB update on every resolved taken branch, whether or not it was mispredicted.
  always_comb begin
    btb_wr_en     = ex_valid & ex_br_taken;
    btb_wr_idx    = ex_pc[BTB_IDX_W+1:2];
    btb_wr_target = ex_target;
  end

  // Next PC: a redirect from EX beats stall so a stalled front end still recovers.
  always_comb begin
    pc_d = if_next;
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID: held on stall, flushed on mispredict.
  pred_meta_reg u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (mispredict),
    .hold   (stall),
    .bubble (1'b0),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  // ID/EX: takes a bubble on stall, flushed on mispredict.
  pred_meta_reg u_id_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (mispredict),
    .hold   (1'b0),
    .bubble (stall),
    .d      (if_id_q),
    .q      (id_ex_q)
  );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios with literal
// expectations, then randomized traffic checked against an instruction-level model.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc_if;
  logic [5:0]  btb_rd_idx;
  logic [31:0] btb_target;
  logic        btb_valid;
  logic        pred_taken_in;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        btb_wr_en;
  logic [5:0]  btb_wr_idx;
  logic [31:0] btb_wr_target;

  fetch_pc_gen #(
    .PC_WIDTH  (32),
    .BTB_IDX_W (6),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .pc_if         (pc_if),
    .btb_rd_idx    (btb_rd_idx),
    .btb_target    (btb_target),
    .btb_valid     (btb_valid),
    .pred_taken_in (pred_taken_in),
    .ex_is_branch  (ex_is_branch),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .btb_wr_en     (btb_wr_en),
    .btb_wr_idx    (btb_wr_idx),
    .btb_wr_target (btb_wr_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one record per in-flight instruction (the one being decoded and the
  // one in EX), plus the PC fetch is presenting.
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          pt;
    logic [31:0] tgt;
  } ins_t;

  ins_t        m_dec;
  ins_t        m_ex;
  logic [31:0] m_pc;

  bit          e_pred;
  bit          e_brt;
  bit          e_mis;
  bit          e_wr;
  logic [31:0] e_seq;
  logic [31:0] e_redir;
  logic [31:0] e_fetch_next;

  // Compare DUT against the model mid-cycle, then advance the model to the
  // state the coming rising edge will produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc  = RST_PC;
      m_dec = '{valid: 1'b0, pc: '0, pt: 1'b0, tgt: '0};
      m_ex  = '{valid: 1'b0, pc: '0, pt: 1'b0, tgt: '0};
      chk("m_rst_pc", pc_if, RST_PC);
      chk("m_rst_mis", 32'(mispredict), 32'd0);
      chk("m_rst_wr", 32'(btb_wr_en), 32'd0);
    end else begin
      e_pred       = btb_valid && pred_taken_in;
      e_seq        = m_pc + 32'd4;
      e_fetch_next = e_pred ? btb_target : e_seq;
      e_brt        = ex_is_branch && ex_taken;
      e_mis        = m_ex.valid && ((m_ex.pt != e_brt) || (e_brt && m_ex.tgt != ex_target));
      e_redir      = (ex_is_branch && ex_taken) ? ex_target : m_ex.pc + 32'd4;
      e_wr         = m_ex.valid && e_brt;

      chk("m_pc_if", pc_if, m_pc);
      chk("m_rd_idx", 32'(btb_rd_idx), 32'(m_pc[7:2]));
      chk("m_mispredict", 32'(mispredict), 32'(e_mis));
      chk("m_wr_en", 32'(btb_wr_en), 32'(e_wr));
      chk("m_wr_target", btb_wr_target, ex_target);
      if (e_mis) chk("m_redirect", redirect_pc, e_redir);
      if (e_wr) chk("m_wr_idx", 32'(btb_wr_idx), 32'(m_ex.pc[7:2]));

      if (e_mis) begin
        m_pc        = e_redir;
        m_dec.valid = 1'b0;
        m_ex.valid  = 1'b0;
      end else if (stall) begin
        m_ex.valid = 1'b0;
      end else begin
        m_ex  = m_dec;
        m_dec = '{valid: 1'b1, pc: m_pc, pt: e_pred, tgt: e_fetch_next};
        m_pc  = e_fetch_next;
      end
    end
  end

  task automatic clear_in();
    stall         = 1'b0;
    btb_target    = '0;
    btb_valid     = 1'b0;
    pred_taken_in = 1'b0;
    ex_is_branch  = 1'b0;
    ex_taken      = 1'b0;
    ex_target     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset held across a falling edge; returns just after release with pc_if = RST_PC.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    #1;
    chk("rst_pc", pc_if, RST_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_ex(input bit br, input bit tk, input logic [31:0] tg);
    ex_is_branch = br;
    ex_taken     = tk;
    ex_target    = tg;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    #1;
    chk("reset_pc", pc_if, RST_PC);
    chk("reset_mis", 32'(mispredict), 32'd0);
    chk("reset_wr", 32'(btb_wr_en), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential fetch, then a correctly predicted taken branch at 0x10.
    #1 chk("seq0", pc_if, 32'h0);
    tick(); #1 chk("seq4", pc_if, 32'h4);
    tick(); #1 chk("seq8", pc_if, 32'h8);
    tick(); #1 chk("seqC", pc_if, 32'hC);
    chk("seq_mis", 32'(mispredict), 32'd0);
    chk("seq_wr", 32'(btb_wr_en), 32'd0);
    tick();
    btb_valid = 1'b1; btb_target = 32'h40; pred_taken_in = 1'b1;
    #1 chk("pc10", pc_if, 32'h10);
    chk("rd_idx10", 32'(btb_rd_idx), 32'd4);
    tick(); clear_in();
    #1 chk("pc40", pc_if, 32'h40);
    tick(); set_ex(1'b1, 1'b1, 32'h40);
    #1 chk("hit_mis", 32'(mispredict), 32'd0);
    chk("hit_wr", 32'(btb_wr_en), 32'd1);
    chk("hit_wr_idx", 32'(btb_wr_idx), 32'd4);
    chk("hit_wr_tgt", btb_wr_target, 32'h40);
    chk("pc44", pc_if, 32'h44);
    tick(); clear_in();

    // Branch at 0x20 predicted not-taken, resolves taken to 0x80.
    do_reset();
    go(8);
    #1 chk("pc20", pc_if, 32'h20);
    go(2); set_ex(1'b1, 1'b1, 32'h80);
    #1 chk("nt_mis", 32'(mispredict), 32'd1);
    chk("nt_redir", redirect_pc, 32'h80);
    tick();
    #1 chk("pc80", pc_if, 32'h80);
    chk("flush1_mis", 32'(mispredict), 32'd0);
    chk("flush1_wr", 32'(btb_wr_en), 32'd0);
    tick();
    #1 chk("flush2_mis", 32'(mispredict), 32'd0);
    chk("flush2_wr", 32'(btb_wr_en), 32'd0);
    tick(); clear_in();

    // Non-branch at 0x30 predicted taken to 0x100 (aliased BTB entry).
    do_reset();
    go(12);
    btb_valid = 1'b1; btb_target = 32'h100; pred_taken_in = 1'b1;
    #1 chk("pc30", pc_if, 32'h30);
    tick(); clear_in();
    #1 chk("pc100", pc_if, 32'h100);
    tick();
    #1 chk("alias_mis", 32'(mispredict), 32'd1);
    chk("alias_redir", redirect_pc, 32'h34);
    chk("alias_wr", 32'(btb_wr_en), 32'd0);
    tick();
    #1 chk("pc34", pc_if, 32'h34);

    // Three stall cycles at 0x8, then stall together with a mispredict.
    do_reset();
    go(2);
    stall = 1'b1;
    #1 chk("stall_pc0", pc_if, 32'h8);
    for (int i = 1; i <= 3; i++) begin
      tick();
      set_ex(1'b1, 1'b1, 32'h300);
      if (i == 3) stall = 1'b0;
      #1 chk("stall_pc", pc_if, 32'h8);
      chk("bubble_mis", 32'(mispredict), 32'd0);
      chk("bubble_wr", 32'(btb_wr_en), 32'd0);
    end
    tick();
    stall = 1'b1; set_ex(1'b1, 1'b1, 32'h200);
    #1 chk("pcC_after_stall", pc_if, 32'hC);
    chk("stall_mis", 32'(mispredict), 32'd1);
    chk("stall_redir", redirect_pc, 32'h200);
    tick(); clear_in();
    #1 chk("pc200", pc_if, 32'h200);

    // Wrap at the top of the address space, then asynchronous reset mid-cycle.
    do_reset();
    go(2); set_ex(1'b1, 1'b1, 32'hFFFF_FFFC);
    #1 chk("wrap_mis", 32'(mispredict), 32'd1);
    tick(); clear_in();
    #1 chk("pc_top", pc_if, 32'hFFFF_FFFC);
    chk("rd_idx_top", 32'(btb_rd_idx), 32'h3F);
    tick();
    #1 chk("pc_wrap", pc_if, 32'h0);
    go(2);
    #1 chk("pc_pre_rst", pc_if, 32'h8);
    rst_n = 1'b0;
    set_ex(1'b1, 1'b1, 32'h500);
    #1 chk("async_pc", pc_if, RST_PC);
    chk("async_mis", 32'(mispredict), 32'd0);
    chk("async_wr", 32'(btb_wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_in();

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      stall         = ($urandom_range(4) == 0);
      btb_valid     = 1'($urandom_range(1));
      pred_taken_in = 1'($urandom_range(1));
      btb_target    = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      if (m_ex.valid && $urandom_range(4) < 3) begin
        // Mostly confirm what was predicted so long correct streams occur.
        ex_is_branch = m_ex.pt | 1'($urandom_range(1));
        ex_taken     = m_ex.pt;
        ex_target    = m_ex.pt ? m_ex.tgt : ($urandom() & 32'hFFFF_FFFC);
      end else begin
        ex_is_branch = 1'($urandom_range(1));
        ex_taken     = 1'($urandom_range(1));
        ex_target    = $urandom_range(1) ? m_ex.tgt : ($urandom() & 32'hFFFF_FFFC);
      end
      if ($urandom_range(399) == 0) begin
        #2;
        rst_n = 1'b0;
      end
    end
    tick();
    rst_n = 1'b1;
    clear_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
